// File: rtl/game_report_tx.sv
// game_report_tx: status reporter for the card game over the Bluetooth UART link.
// A trigger (explicit request or a change of game state) snapshots the game
// controller's state and sends it as a fixed frame on tx_pin (8N1, LSB first).
// Optional feature macro: REPORT_CHECKSUM_EN appends an XOR checksum byte (7-byte
// frame). Without it the frame is 6 bytes and there is no checksum logic.
module game_report_tx #(
  parameter int CLK_FRE   = 25,    // clock frequency in MHz
  parameter int BAUD_RATE = 9600   // line rate in bit/s
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_req,
  input  logic [1:0]  state,
  input  logic [3:0]  card_select,
  input  logic [15:0] card_find,
  input  logic [11:0] left_time,
  output logic        tx_pin,
  output logic        busy,
  output logic        frame_done
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);
  // Count value one cycle before the final cycle of a bit (only used when CYCLE > 1)
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'((CYCLE > 1) ? CYCLE - 2 : 0);

`ifdef REPORT_CHECKSUM_EN
  localparam int N_BYTES = 7;
`else
  localparam int N_BYTES = 6;
`endif
  localparam logic [2:0] LAST_BYTE = 3'(N_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } fsm_t;

  fsm_t             fsm_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [2:0]       byte_idx_reg;
  logic             pending_reg;
  logic [1:0]       prev_state_reg;
  logic             tx_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [1:0]       snap_state_reg;
  logic [3:0]       snap_sel_reg;
  logic [15:0]      snap_find_reg;
  logic [11:0]      snap_time_reg;

  logic             trig;
  logic             cnt_end;
  logic             last_byte;
  logic             start_frame;
  logic             done_next;
  logic [7:0]       cur_byte;
  logic [7:0]       frame_byte [N_BYTES];

  assign trig      = send_req | (state != prev_state_reg);
  assign cnt_end   = (cnt_reg == CNT_LAST);
  assign last_byte = (byte_idx_reg == LAST_BYTE);

  // A new frame begins either from idle or straight after the last stop bit
  // when a trigger is waiting (or arrives on that very edge).
  assign start_frame = ((fsm_reg == S_IDLE) && trig) ||
                       ((fsm_reg == S_STOP) && cnt_end && last_byte && (pending_reg || trig));

  // Frame layout, built from the snapshot so mid-frame input changes are ignored
  assign frame_byte[0] = 8'hA5;
  assign frame_byte[1] = {2'b00, snap_state_reg, snap_sel_reg};
  assign frame_byte[2] = snap_find_reg[15:8];
  assign frame_byte[3] = snap_find_reg[7:0];
  assign frame_byte[4] = {4'h0, snap_time_reg[11:8]};
  assign frame_byte[5] = snap_time_reg[7:0];

`ifdef REPORT_CHECKSUM_EN
  // XOR of payload bytes B1..B5, accumulated as a chain
  logic [7:0] chk_acc [6];
  assign chk_acc[0] = 8'h00;
  generate
    for (genvar gi = 1; gi < 6; gi++) begin : g_chk
      assign chk_acc[gi] = chk_acc[gi-1] ^ frame_byte[gi];
    end
  endgenerate
  assign frame_byte[6] = chk_acc[5];
`endif

  assign cur_byte = frame_byte[byte_idx_reg];

  // frame_done is registered, so it is raised on the edge that enters the final
  // cycle of the last stop bit.
  generate
    if (CYCLE > 1) begin : g_done_multi
      assign done_next = (fsm_reg == S_STOP) && last_byte && (cnt_reg == CNT_PRE);
    end else begin : g_done_single
      assign done_next = (fsm_reg == S_DATA) && last_byte && (bit_idx_reg == 3'd7);
    end
  endgenerate

  // Capture the game inputs whenever a frame starts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_state_reg <= '0;
      snap_sel_reg   <= '0;
      snap_find_reg  <= '0;
      snap_time_reg  <= '0;
    end else if (start_frame) begin
      snap_state_reg <= state;
      snap_sel_reg   <= card_select;
      snap_find_reg  <= card_find;
      snap_time_reg  <= left_time;
    end
  end

  // Bit/byte FSM with baud counter, pending-request flag and registered line outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg        <= S_IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      byte_idx_reg   <= '0;
      pending_reg    <= 1'b0;
      prev_state_reg <= '0;
      tx_reg         <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      prev_state_reg <= state;
      done_reg       <= done_next;
      // Triggers during a frame collapse into a single pending frame
      if ((fsm_reg != S_IDLE) && trig) begin
        pending_reg <= 1'b1;
      end
      case (fsm_reg)
        S_IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (trig) begin
            fsm_reg      <= S_START;
            cnt_reg      <= '0;
            byte_idx_reg <= '0;
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_end) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            fsm_reg     <= S_DATA;
            tx_reg      <= cur_byte[0];
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_end) begin
            cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              fsm_reg <= S_STOP;
              tx_reg  <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= cur_byte[bit_idx_reg + 3'd1];
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_end) begin
            cnt_reg <= '0;
            if (!last_byte) begin
              byte_idx_reg <= byte_idx_reg + 3'd1;
              fsm_reg      <= S_START;
              tx_reg       <= 1'b0;
            end else if (pending_reg || trig) begin
              // Back-to-back frame: no idle gap, busy stays high
              pending_reg  <= 1'b0;
              byte_idx_reg <= '0;
              fsm_reg      <= S_START;
              tx_reg       <= 1'b0;
            end else begin
              pending_reg <= 1'b0;
              fsm_reg     <= S_IDLE;
              tx_reg      <= 1'b1;
              busy_reg    <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          fsm_reg  <= S_IDLE;
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign tx_pin     = tx_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_game_report_tx.sv
// tb_game_report_tx: randomized self-checking bench for game_report_tx.
// The line is logged every cycle and decoded at mid-bit; expected frames and
// timing come from a byte-level model of the report format.
module tb_game_report_tx;

  localparam int C = 10;   // CLK_FRE=1, BAUD_RATE=100000
`ifdef REPORT_CHECKSUM_EN
  localparam int N = 7;
`else
  localparam int N = 6;
`endif
  localparam int FL    = N * 10 * C;
  localparam int LOG_N = 32768;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send_req = 1'b0;
  logic [1:0]  state = 2'd0;
  logic [3:0]  card_select = 4'd0;
  logic [15:0] card_find = 16'd0;
  logic [11:0] left_time = 12'd0;
  logic        tx_pin;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int ncnt  = 0;
  logic tx_log   [LOG_N];
  logic busy_log [LOG_N];
  logic fd_log   [LOG_N];

  game_report_tx #(.CLK_FRE(1), .BAUD_RATE(100000)) dut (
    .clk(clk), .rst_n(rst_n), .send_req(send_req), .state(state),
    .card_select(card_select), .card_find(card_find), .left_time(left_time),
    .tx_pin(tx_pin), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Cycle log, sampled mid-cycle: index n holds the n-th negedge sample
  always @(negedge clk) begin
    if (ncnt < LOG_N) begin
      tx_log[ncnt]   <= tx_pin;
      busy_log[ncnt] <= busy;
      fd_log[ncnt]   <= frame_done;
    end
    ncnt <= ncnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference frame: byte i at [8*i +: 8]
  function automatic logic [55:0] model_frame(input logic [1:0] st, input logic [3:0] sel,
                                              input logic [15:0] find, input logic [11:0] lt);
    logic [7:0] b [7];
    logic [55:0] r;
    b[0] = 8'hA5;
    b[1] = 8'(st * 16 + sel);
    b[2] = 8'(find / 256);
    b[3] = 8'(find % 256);
    b[4] = 8'(lt / 256);
    b[5] = 8'(lt % 256);
    b[6] = 8'h00;
    for (int i = 1; i <= 5; i++) b[6] = b[6] ^ b[i];
    r = '0;
    for (int i = 0; i < 7; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  // Decode one byte whose start bit begins at log index i0
  function automatic logic [7:0] dec_byte(input int i0);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = tx_log[i0 + (1 + i) * C + C / 2];
    return v;
  endfunction

  function automatic bit framing_ok(input int i0);
    return (tx_log[i0 + C / 2] === 1'b0) && (tx_log[i0 + 9 * C + C / 2] === 1'b1);
  endfunction

  function automatic int count_fd(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (fd_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_busy(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (busy_log[i] !== 1'b0) n++;
    return n;
  endfunction

  task automatic wait_log(input int upto);
    while (ncnt < upto) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    int errs = 0;
    rst_n = 1'b0; send_req = 1'b0; state = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if ({tx_pin, busy, frame_done} !== 3'b100) begin
        bad++; errs++;
        $display("FAIL reset_idle cycle %0d: tx/busy/done=%b required 100", i, {tx_pin, busy, frame_done});
      end
    end
    $display("reset: 100 idle cycles, errors=%0d", errs);
  endtask

  task automatic test_single_frame(input logic [1:0] st, input logic [3:0] sel,
                                   input logic [15:0] find, input logic [11:0] lt);
    logic [55:0] exp;
    logic [7:0]  got;
    int base, ferr;
    exp = model_frame(st, sel, find, lt);
    @(negedge clk);
    state = st; card_select = sel; card_find = find; left_time = lt; send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    base = ncnt;
    // Mid-frame changes of non-state inputs must not reach this frame
    repeat (FL / 2) @(negedge clk);
    card_select = 4'($urandom); card_find = 16'($urandom); left_time = 12'($urandom);
    wait_log(base + FL + 20);
    total++;
    if (busy_log[base - 1] !== 1'b0 || busy_log[base] !== 1'b1) begin
      bad++; $display("FAIL frame_busy_rise: before/after=%b%b required 01", busy_log[base - 1], busy_log[base]);
    end
    total++;
    if (tx_log[base] !== 1'b0) begin
      bad++; $display("FAIL frame_start_bit: tx=%b required 0", tx_log[base]);
    end
    ferr = 0;
    for (int b = 0; b < N; b++) begin
      got = dec_byte(base + b * 10 * C);
      if (!framing_ok(base + b * 10 * C)) ferr++;
      total++;
      if (got !== exp[8*b +: 8]) begin
        bad++; $display("FAIL frame_byte%0d: got %h required %h", b, got, exp[8*b +: 8]);
      end
    end
    total++;
    if (ferr != 0) begin
      bad++; $display("FAIL frame_framing: bad start/stop bits=%0d required 0", ferr);
    end
    total++;
    if (fd_log[base + FL - 1] !== 1'b1 || count_fd(base, base + FL + 20) != 1) begin
      bad++; $display("FAIL frame_done_pulse: at end=%b count=%0d required 1 and 1",
                      fd_log[base + FL - 1], count_fd(base, base + FL + 20));
    end
    total++;
    if (count_busy(base, base + FL) != FL || busy_log[base + FL] !== 1'b0 || tx_log[base + FL] !== 1'b1) begin
      bad++; $display("FAIL frame_busy_fall: busy cycles=%0d after busy/tx=%b%b required %0d and 01",
                      count_busy(base, base + FL), busy_log[base + FL], tx_log[base + FL], FL);
    end
    $display("frame st=%0d sel=%h find=%h time=%h sent, expected bytes=%h", st, sel, find, lt, exp);
  endtask

  task automatic test_state_change();
    logic [55:0] exp;
    logic [7:0]  b1;
    int base;
    exp = model_frame(2'd1, card_select, card_find, left_time);
    @(negedge clk);
    state = 2'd1;
    @(posedge clk);
    #1 base = ncnt;
    wait_log(base + FL + 200);
    b1 = dec_byte(base + 10 * C);
    total++;
    if (busy_log[base] !== 1'b1 || tx_log[base] !== 1'b0) begin
      bad++; $display("FAIL state_trig_start: busy/tx=%b%b required 10", busy_log[base], tx_log[base]);
    end
    total++;
    if (b1 !== exp[15:8]) begin
      bad++; $display("FAIL state_trig_b1: got %h required %h", b1, exp[15:8]);
    end
    total++;
    if (count_fd(base, base + FL + 200) != 1 || count_busy(base + FL, base + FL + 200) != 0) begin
      bad++; $display("FAIL state_hold_no_refire: done pulses=%0d busy after=%0d required 1 and 0",
                      count_fd(base, base + FL + 200), count_busy(base + FL, base + FL + 200));
    end
    $display("state change 0->1: one frame, B1=%h", b1);
  endtask

  task automatic test_back_to_back();
    logic [55:0] exp1, exp2;
    logic [3:0]  sel0;
    int base, errs;
    sel0 = 4'($urandom);
    card_find = 16'($urandom); left_time = 12'($urandom);
    exp1 = model_frame(state, sel0, card_find, left_time);
    exp2 = model_frame(state, sel0 ^ 4'hF, card_find, left_time);
    @(negedge clk);
    card_select = sel0; send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    base = ncnt;
    for (int k = 0; k < 2; k++) begin
      repeat (100) @(negedge clk);
      send_req = 1'b1;
      @(posedge clk);
      #1 send_req = 1'b0;
    end
    repeat (100) @(negedge clk);
    card_select = sel0 ^ 4'hF;
    wait_log(base + 2 * FL + 150);
    total++;
    if (tx_log[base + FL] !== 1'b0 || busy_log[base + FL] !== 1'b1) begin
      bad++; $display("FAIL b2b_no_gap: tx/busy=%b%b required 01", tx_log[base + FL], busy_log[base + FL]);
    end
    errs = 0;
    for (int b = 0; b < N; b++) begin
      if (dec_byte(base + b * 10 * C) !== exp1[8*b +: 8]) errs++;
      if (dec_byte(base + FL + b * 10 * C) !== exp2[8*b +: 8]) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL b2b_bytes: wrong bytes=%0d required 0 (B1 got %h/%h required %h/%h)", errs,
                      dec_byte(base + 10 * C), dec_byte(base + FL + 10 * C), exp1[15:8], exp2[15:8]);
    end
    total++;
    if (count_fd(base, base + 2 * FL + 150) != 2 || fd_log[base + 2 * FL - 1] !== 1'b1) begin
      bad++; $display("FAIL b2b_done_count: pulses=%0d last=%b required 2 and 1",
                      count_fd(base, base + 2 * FL + 150), fd_log[base + 2 * FL - 1]);
    end
    total++;
    if (count_busy(base + 2 * FL, base + 2 * FL + 150) != 0) begin
      bad++; $display("FAIL b2b_single_extra: busy cycles after 2nd frame=%0d required 0",
                      count_busy(base + 2 * FL, base + 2 * FL + 150));
    end
    $display("back-to-back: sel %h then %h", sel0, sel0 ^ 4'hF);
  endtask

  task automatic test_done_edge();
    logic [55:0] exp2;
    logic [11:0] lt2;
    int base, errs;
    left_time = 12'($urandom);
    lt2 = ~left_time;
    exp2 = model_frame(state, card_select, card_find, lt2);
    @(negedge clk);
    send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    base = ncnt;
    repeat (FL) @(negedge clk);
    total++;
    if (frame_done !== 1'b1) begin
      bad++; $display("FAIL edge_done_here: frame_done=%b required 1", frame_done);
    end
    send_req = 1'b1; left_time = lt2;
    @(posedge clk);
    #1 send_req = 1'b0;
    wait_log(base + 2 * FL + 50);
    total++;
    if (tx_log[base + FL] !== 1'b0 || busy_log[base + FL] !== 1'b1) begin
      bad++; $display("FAIL edge_restart: tx/busy=%b%b required 01", tx_log[base + FL], busy_log[base + FL]);
    end
    errs = 0;
    for (int b = 0; b < N; b++) if (dec_byte(base + FL + b * 10 * C) !== exp2[8*b +: 8]) errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL edge_bytes: wrong bytes=%0d required 0", errs);
    end
    total++;
    if (count_fd(base, base + 2 * FL + 50) != 2 || busy_log[base + 2 * FL] !== 1'b0) begin
      bad++; $display("FAIL edge_end: pulses=%0d busy after=%b required 2 and 0",
                      count_fd(base, base + 2 * FL + 50), busy_log[base + 2 * FL]);
    end
    $display("trigger on frame_done cycle: follow-up frame time=%h", lt2);
  endtask

  task automatic test_reset_mid();
    int errs = 0;
    @(negedge clk);
    card_select = 4'($urandom); send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    repeat (23 * C + 4) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midreset_active: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (tx_pin !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset_abort: tx/busy=%b%b required 10", tx_pin, busy);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ({tx_pin, busy, frame_done} !== 3'b100) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL midreset_no_resume: non-idle cycles=%0d required 0", errs);
    end
    $display("reset during bit 23: frame aborted");
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_state_change();
    test_single_frame(2'd2, 4'd5, 16'h1234, 12'h3C7);
    for (int r = 0; r < 4; r++) begin
      test_single_frame(2'($urandom), 4'($urandom), 16'($urandom), 12'($urandom));
    end
    test_back_to_back();
    test_done_edge();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
